// File: rtl/smss_power_map_seq.sv
// ---------------------------------------------------------------------------
// smss_power_map_seq
//
// Iterative power-map S-box: computes y = x^e over GF(2^N) in polynomial
// basis, reduced modulo POLY. The exponent is supplied at runtime.
// Square-and-multiply runs MSB first, one exponent bit per clock.
//
// Optional build macro: SMSS_AFFINE_EN
//   defined   : y = x^e XOR {N{^(x & MASK)}} (masked parity broadcast)
//   undefined : y = x^e (MASK has no effect)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and its payload stable until that edge.
// Ready may be asserted without valid. in_ready is high only in IDLE, so
// requests are never queued. out_valid with y_out is held until out_ready.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request valid
//   in_ready   out  engine can accept a request (IDLE)
//   x_in       in   [N-1:0] field element operand
//   e_in       in   [N-1:0] unsigned exponent
//   out_valid  out  result valid
//   out_ready  in   downstream accepts the result
//   y_out      out  [N-1:0] registered result
//   busy       out  high in RUN or DONE
// ---------------------------------------------------------------------------
module smss_power_map_seq #(
  parameter int             N    = 6,
  parameter logic [N:0]     POLY = 7'h43,
  parameter logic [N-1:0]   MASK = 6'h14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x_in,
  input  logic [N-1:0] e_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y_out,
  output logic         busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

`ifdef SMSS_AFFINE_EN
  localparam logic AFFINE_ON = 1'b1;
`else
  localparam logic AFFINE_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   x_q, x_d;
  logic [N-1:0]   e_q, e_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [N-1:0]   y_q, y_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ov_q, ov_d;

  logic [N-1:0]   step;
  logic [N-1:0]   affine;

  // Shift-and-add field multiply: the running multiplicand is multiplied by
  // the generator (shift, fold top bit back via POLY) each position, which is
  // the carry-less product reduced modulo POLY.
  function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a,
                                          input logic [N-1:0] b);
    logic [N-1:0] p;
    logic [N-1:0] s;
    p = '0;
    s = a;
    for (int i = 0; i < N; i++) begin
      if (b[i]) p = p ^ s;
      s = s[N-1] ? ((s << 1) ^ POLY[N-1:0]) : (s << 1);
    end
    return p;
  endfunction

  // One square-and-multiply step for exponent bit cnt.
  assign step   = gf_mul(gf_mul(acc_q, acc_q), e_q[cnt_q] ? x_q : ONE);
  assign affine = {N{AFFINE_ON & (^(x_q & MASK))}};

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    e_d     = e_q;
    acc_d   = acc_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = x_in;
          e_d     = e_in;
          acc_d   = ONE;
          cnt_d   = CW'(N - 1);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          cnt_d   = '0;
          y_d     = step ^ affine;
          ov_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        ov_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      e_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      e_q     <= e_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = ov_q;
  assign y_out     = y_q;

endmodule
